// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer: FSM states, instruction
// class field, legal ALU function ranges, branch and system codes.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU_R  = 2'b00,
        CLS_ALU_I  = 2'b01,
        CLS_BRANCH = 2'b10,
        CLS_SYS    = 2'b11
    } cls_t;

    // Legal ALU function selects: a low contiguous block and a short high block.
    localparam logic [4:0] FS_LO_LAST  = 5'd11;
    localparam logic [4:0] FS_HI_FIRST = 5'd28;
    localparam logic [4:0] FS_HI_LAST  = 5'd30;

    localparam logic [4:0] BR_BZ  = 5'd0;
    localparam logic [4:0] BR_BNZ = 5'd1;
    localparam logic [4:0] BR_BN  = 5'd2;
    localparam logic [4:0] BR_BC  = 5'd3;
    localparam logic [4:0] BR_BV  = 5'd4;
    localparam logic [4:0] BR_JMP = 5'd5;

    localparam logic [4:0] SYS_NOP  = 5'd0;
    localparam logic [4:0] SYS_HALT = 5'd1;

    // Latched ALU status, in {c, v, z, n} order.
    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    function automatic logic fs_legal(input logic [4:0] f);
        return (f <= FS_LO_LAST) || ((f >= FS_HI_FIRST) && (f <= FS_HI_LAST));
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation against the latched flag register.
module branch_cond
    import ctrl_pkg::*;
(
    input  logic [4:0] code,
    input  flags_t     flags,
    output logic       taken
);

    // Map branch code to its flag test; unknown codes never branch.
    always_comb begin
        taken = 1'b0;
        case (code)
            BR_BZ:   taken = flags.z;
            BR_BNZ:  taken = ~flags.z;
            BR_BN:   taken = flags.n;
            BR_BC:   taken = flags.c;
            BR_BV:   taken = flags.v;
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer driving an external ALU and
// register file. Optional retired-instruction counter: CTRL_RETIRE_CNT_EN.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [4:0]  fs,
    output logic [4:0]  sh,
    output logic [4:0]  rf_wa,
    output logic [4:0]  rf_ra_a,
    output logic [4:0]  rf_ra_b,
    output logic        rf_we,
    output logic        b_sel,
    output logic [31:0] imm,
    input  logic        alu_c,
    input  logic        alu_v,
    input  logic        alu_z,
    input  logic        alu_n,
    output logic        halted,
    output logic        illegal
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, ir;
    flags_t      flags;
    cls_t        cls;
    logic [4:0]  code;
    logic        legal, is_alu, is_halt, taken, exec, dec_ex;

    assign cls     = cls_t'(ir[31:30]);
    assign code    = ir[29:25];
    assign is_alu  = (cls == CLS_ALU_R) || (cls == CLS_ALU_I);
    assign is_halt = (cls == CLS_SYS) && (code == SYS_HALT);
    assign exec    = (state == ST_EXECUTE);
    assign dec_ex  = (state == ST_DECODE) || exec;

    branch_cond u_bc (
        .code  (code),
        .flags (flags),
        .taken (taken)
    );

    // Opcode legality per instruction class.
    always_comb begin
        legal = 1'b0;
        case (cls)
            CLS_ALU_R, CLS_ALU_I: legal = fs_legal(code);
            CLS_BRANCH:           legal = (code <= BR_JMP);
            default:              legal = (code <= SYS_HALT);
        endcase
    end

    // Next PC: relative branch target, hold on HALT, else sequential.
    always_comb begin
        pc_nx = pc;
        if ((cls == CLS_BRANCH) && taken)
            pc_nx = pc + 32'd1 + {{17{ir[14]}}, ir[14:0]};
        else if (!is_halt)
            pc_nx = pc + 32'd1;
    end

    // FSM next state; HALT only leaves through reset.
    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH:   if (imem_valid) state_nx = ST_DECODE;
            ST_DECODE:  state_nx = ST_EXECUTE;
            ST_EXECUTE: state_nx = (!legal || is_halt) ? ST_HALT : ST_FETCH;
            default:    state_nx = ST_HALT;
        endcase
    end

    // Architectural state: FSM, IR capture, PC/flag commit, sticky illegal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FETCH;
            pc      <= '0;
            ir      <= '0;
            flags   <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if ((state == ST_FETCH) && imem_valid) ir <= imem_rdata;
            if (exec && legal) pc <= pc_nx;
            if (exec && legal && is_alu) flags <= '{c: alu_c, v: alu_v, z: alu_z, n: alu_n};
            if (exec && !legal) illegal <= 1'b1;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    // Count every committed legal instruction except HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired <= '0;
        else if (exec && legal && !is_halt)
            retired <= retired + 32'd1;
    end
`endif

    // Request is gated by reset so it drops immediately while rst_n is low.
    assign imem_req  = rst_n && (state == ST_FETCH);
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);
    assign rf_we     = exec && legal && is_alu;
    assign fs        = dec_ex ? code : 5'd0;
    assign rf_wa     = dec_ex ? ir[24:20] : 5'd0;
    assign rf_ra_a   = dec_ex ? ir[19:15] : 5'd0;
    assign rf_ra_b   = dec_ex ? ir[14:10] : 5'd0;
    assign sh        = dec_ex ? ir[4:0] : 5'd0;
    assign b_sel     = dec_ex && (cls == CLS_ALU_I);
    assign imm       = dec_ex ? {17'd0, ir[14:0]} : 32'd0;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus
// randomized instruction streams against an instruction-level model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [4:0]  fs, sh, rf_wa, rf_ra_a, rf_ra_b;
    logic        rf_we, b_sel;
    logic [31:0] imm;
    logic        alu_c, alu_v, alu_z, alu_n;
    logic        halted, illegal;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction-level model state.
    logic [31:0] m_pc;
    logic [3:0]  m_flags;   // {c, v, z, n}
    bit          m_halt, m_ill;
    logic [31:0] m_ret;

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .fs(fs), .sh(sh), .rf_wa(rf_wa), .rf_ra_a(rf_ra_a), .rf_ra_b(rf_ra_b),
        .rf_we(rf_we), .b_sel(b_sel), .imm(imm),
        .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
        .halted(halted), .illegal(illegal)
`ifdef CTRL_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit op_legal(input logic [6:0] op);
        int cls  = int'(op[6:5]);
        int code = int'(op[4:0]);
        if (cls < 2) return (code <= 11) || (code >= 28 && code <= 30);
        if (cls == 2) return code <= 5;
        return code <= 1;
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        do w = $urandom; while (!op_legal(w[31:25]) || w[31:25] == 7'b1100001);
        return w;
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [31:0] w;
        do w = $urandom; while (op_legal(w[31:25]));
        return w;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        imem_valid = 1'b1;
        #1;
        chk("rst_req", imem_req, 0);     chk("rst_we", rf_we, 0);
        chk("rst_halted", halted, 0);    chk("rst_illegal", illegal, 0);
        chk("rst_fs", fs, 0);            chk("rst_sh", sh, 0);
        chk("rst_wa", rf_wa, 0);         chk("rst_ra_a", rf_ra_a, 0);
        chk("rst_ra_b", rf_ra_b, 0);     chk("rst_bsel", b_sel, 0);
        chk("rst_imm", imm, 0);          chk("rst_addr", imem_addr, 0);
`ifdef CTRL_RETIRE_CNT_EN
        chk("rst_retired", retired, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        imem_valid = 1'b0;
        m_pc = 0; m_flags = 0; m_halt = 0; m_ill = 0; m_ret = 0;
    endtask

    // One instruction: fetch with dly wait cycles, decode, execute with ALU
    // flags fl = {c,v,z,n}; abort asserts reset in the execute cycle.
    task automatic run_instr(input logic [31:0] instr, input int dly,
                             input logic [3:0] fl, input bit abort);
        logic [6:0] op = instr[31:25];
        bit legal = op_legal(op);
        bit is_alu = (op[6:5] < 2);
        bit taken;
        logic signed [31:0] off;
        for (int i = 0; i <= dly; i++) begin
            #1;
            chk("fetch_req", imem_req, 1);
            chk("fetch_addr", imem_addr, m_pc);
            chk("fetch_fs", fs, 0);
            if (i == dly) begin imem_valid = 1'b1; imem_rdata = instr; end
            else begin imem_valid = 1'b0; imem_rdata = $urandom; end
            @(negedge clk);
        end
        // decode: bus noise and live flags here must be ignored
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        {alu_c, alu_v, alu_z, alu_n} = 4'($urandom);
        chk("dec_req", imem_req, 0);       chk("dec_we", rf_we, 0);
        chk("dec_fs", fs, op[4:0]);        chk("dec_wa", rf_wa, instr[24:20]);
        chk("dec_ra_a", rf_ra_a, instr[19:15]);
        chk("dec_ra_b", rf_ra_b, instr[14:10]);
        chk("dec_sh", sh, instr[4:0]);     chk("dec_imm", imm, {17'd0, instr[14:0]});
        chk("dec_bsel", b_sel, op[6:5] == 2'b01);
        @(negedge clk);
        {alu_c, alu_v, alu_z, alu_n} = fl;
        chk("ex_we", rf_we, legal && is_alu);
        chk("ex_fs", fs, op[4:0]);
        if (abort) begin
            rst_n = 1'b0;
            #1;
            chk("abort_we", rf_we, 0);
            chk("abort_addr", imem_addr, 0);
            chk("abort_req", imem_req, 0);
`ifdef CTRL_RETIRE_CNT_EN
            chk("abort_retired", retired, 0);
`endif
            @(negedge clk);
            rst_n = 1'b1;
            imem_valid = 1'b0;
            m_pc = 0; m_flags = 0; m_halt = 0; m_ill = 0; m_ret = 0;
            return;
        end
        @(negedge clk);
        imem_valid = 1'b0;
        // model commit
        off = $signed(instr[14:0]);
        case (op[4:0])
            5'd0: taken = m_flags[1];
            5'd1: taken = !m_flags[1];
            5'd2: taken = m_flags[0];
            5'd3: taken = m_flags[3];
            5'd4: taken = m_flags[2];
            default: taken = 1;
        endcase
        if (!legal) begin
            m_ill = 1; m_halt = 1;
        end else if (is_alu) begin
            m_flags = fl; m_pc = m_pc + 1; m_ret = m_ret + 1;
        end else if (op[6:5] == 2'b10) begin
            m_pc = taken ? m_pc + 1 + off : m_pc + 1; m_ret = m_ret + 1;
        end else if (op[4:0] == 5'd1) begin
            m_halt = 1;
        end else begin
            m_pc = m_pc + 1; m_ret = m_ret + 1;
        end
        #1;
        chk("post_halted", halted, m_halt);
        chk("post_illegal", illegal, m_ill);
        chk("post_we", rf_we, 0);
`ifdef CTRL_RETIRE_CNT_EN
        chk("retired", retired, m_ret);
`endif
        if (m_halt) begin
            chk("halt_req", imem_req, 0);
            chk("halt_pc", imem_addr, m_pc);
        end
    endtask

    task automatic idle_halted(input int n);
        repeat (n) begin
            imem_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            chk("idle_req", imem_req, 0);     chk("idle_we", rf_we, 0);
            chk("idle_halted", halted, 1);    chk("idle_illegal", illegal, m_ill);
            chk("idle_pc", imem_addr, m_pc);  chk("idle_fs", fs, 0);
        end
    endtask

    localparam logic [31:0] I_ADD  = {7'b0000010, 5'd3, 5'd1, 5'd2, 10'd0};
    localparam logic [31:0] I_SUB  = {7'b0000101, 5'd4, 5'd1, 5'd2, 10'd0};
    localparam logic [31:0] I_NOP  = {7'b1100000, 25'd0};
    localparam logic [31:0] I_HALT = {7'b1100001, 25'd0};
    localparam logic [31:0] I_BZM2 = {7'b1000000, 10'd0, 15'h7FFE};
    localparam logic [31:0] I_BNZ  = {7'b1000001, 10'd0, 15'h7FFE};
    localparam logic [31:0] I_JMPM2 = {7'b1000101, 10'd0, 15'h7FFE};
    localparam logic [31:0] I_JMP0 = {7'b1000101, 25'd0};
    localparam logic [31:0] I_BAD  = {7'b0001100, 5'd7, 5'd1, 5'd2, 10'd0};

    initial begin
        rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        {alu_c, alu_v, alu_z, alu_n} = 4'b0;
        do_reset();
        // ADD with immediate valid; the next fetch checks address 1
        run_instr(I_ADD, 0, 4'b0000, 0);
        // delayed valid: request/address held through the wait
        run_instr(I_NOP, 4, 4'b0000, 0);
        run_instr(I_NOP, 0, 4'b0000, 0);
        run_instr(I_NOP, 1, 4'b0000, 0);
        // SUB sets Z, BZ -2 at PC=5 returns to 4; BNZ falls through to 6
        run_instr(I_SUB, 0, 4'b0010, 0);
        run_instr(I_BZM2, 0, 4'b0000, 0);
        chk("bz_target", imem_addr, 32'd4);
        run_instr(I_SUB, 0, 4'b0010, 0);
        run_instr(I_BNZ, 2, 4'b0000, 0);
        chk("bnz_target", imem_addr, 32'd6);
        // randomized legal stream
        for (int k = 0; k < 40; k++)
            run_instr(rand_legal(), int'($urandom_range(0, 3)), 4'($urandom), 0);
        // reset during execute of an ALU instruction
        do_reset();
        run_instr(I_ADD, 0, 4'b1111, 0);
        run_instr(I_ADD, 1, 4'b1111, 1);
        // PC wrap: 0 -> FFFFFFFF -> 0 -> FFFFFFFF, then HALT there
        run_instr(I_JMPM2, 0, 4'b0000, 0);
        chk("jmp_wrap_down", imem_addr, 32'hFFFF_FFFF);
        run_instr(I_JMP0, 0, 4'b0000, 0);
        chk("jmp_wrap_up", imem_addr, 32'd0);
        run_instr(I_JMPM2, 0, 4'b0000, 0);
        run_instr(I_HALT, 0, 4'b0000, 0);
        chk("halt_pc_top", imem_addr, 32'hFFFF_FFFF);
        idle_halted(3);
        // reset out of HALT, then the illegal FS 01100
        do_reset();
        run_instr(I_ADD, 0, 4'b0101, 0);
        run_instr(I_BAD, 0, 4'b0000, 0);
        idle_halted(4);
        // random illegal opcodes after short legal prologues
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int j = 0; j < 3; j++)
                run_instr(rand_legal(), int'($urandom_range(0, 2)), 4'($urandom), 0);
            run_instr(rand_illegal(), 0, 4'($urandom), 0);
            idle_halted(2);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports imem_req (output, 1, fetch request), imem_addr (output, 32, word address = PC), imem_rdata (input, 32, instruction), and imem_valid (input, 1, rdata valid).
REQ-004 SHALL have ports fs (output, 5, function select to ALU) and sh (output, 5, shift amount).
REQ-005 SHALL have ports rf_wa, rf_ra_a, rf_ra_b (output, 5 each, register addresses) and rf_we (output, 1, register write enable).
REQ-006 SHALL have ports b_sel (output, 1, 0 = register B, 1 = immediate) and imm (output, 32, zero-extended imm15).
REQ-007 SHALL have ports alu_c, alu_v, alu_z, alu_n (input, 1 each, ALU status flags).
REQ-008 SHALL have ports halted (output, 1) and illegal (output, 1, sticky illegal-opcode indication).

Function
REQ-009 SHALL decode instr[31:25] as opcode, [24:20] as DR, [19:15] as SA, [14:10] as SB, [14:0] as imm15, and [4:0] as SH.
REQ-010 SHALL treat opcode[6:5] as the class field: 00 = ALU register, 01 = ALU immediate, 10 = branch, 11 = system.
REQ-011 SHALL treat opcode[4:0] as the FS value for ALU classes; legal values are 00000-01011 and 11100-11110, and all others are illegal.
REQ-012 SHALL implement states FETCH, DECODE, EXECUTE, HALT: FETCH->DECODE on imem_valid; DECODE->EXECUTE always; EXECUTE->FETCH, or EXECUTE->HALT on HALT or illegal; HALT is terminal until reset.
REQ-013 SHALL hold imem_req=1 and imem_addr=PC for every FETCH cycle, and SHALL capture imem_rdata into IR in the cycle imem_valid=1.
REQ-014 SHALL ignore imem_valid outside FETCH.
REQ-015 SHALL drive fs, sh, rf_ra_a, rf_ra_b, rf_wa, b_sel, and imm from IR during DECODE and EXECUTE, and SHALL drive fs=00000 otherwise.
REQ-016 SHALL pulse rf_we for exactly the one EXECUTE cycle of each legal ALU instruction, and never otherwise.
REQ-017 SHALL latch alu_c/v/z/n into a 4-bit flag register at the end of EXECUTE for ALU instructions only; branch and system instructions leave the flags unchanged.
REQ-018 SHALL use branch codes from opcode[4:0]: 0 BZ, 1 BNZ, 2 BN, 3 BC, 4 BV, 5 JMP; codes 6-31 are illegal.
REQ-019 SHALL test branch conditions against the latched flags, not the live ALU flags.
REQ-020 SHALL set PC at the end of EXECUTE to PC+1+sext(imm15) if a branch is taken, and to PC+1 otherwise.
REQ-021 SHALL compute PC modulo 2^32, so wrap-around is silent.
REQ-022 SHALL treat system opcode[4:0]=0 as NOP and 1 as HALT (PC not advanced); all other system codes are illegal.
REQ-023 SHALL, on an illegal instruction: suppress rf_we, leave PC and flags unchanged, set illegal=1, and go to HALT.
REQ-024 SHALL achieve a minimum of 3 cycles per instruction when imem_valid is returned in the first FETCH cycle; each wait cycle adds 1.

Reset
REQ-025 SHALL, on rst_n=0, immediately force: state=FETCH, PC=0, IR=0, flags=0, imem_req=0, rf_we=0, halted=0, illegal=0, and fs/sh/addresses/b_sel/imm=0.
REQ-026 SHALL let reset asserted mid-FETCH, mid-EXECUTE, or in HALT abort the in-flight instruction with no register write.
REQ-027 SHALL assert imem_req in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro CTRL_RETIRE_CNT_EN defined, add output retired (32 bits), reset to 0 and incremented once per completed legal non-HALT instruction, wrapping at 2^32.
REQ-029 SHALL, without CTRL_RETIRE_CNT_EN, have no retired port and no counter logic.

Structure
REQ-030 SHALL place the state enum, class codes, legal FS codes, branch codes, and system codes in shared package ctrl_pkg.
REQ-031 SHALL implement branch condition evaluation (branch code and latched flags in, taken out) as combinational sub-module branch_cond.

Verification
REQ-032 SHALL cover: reset, then ADD (op 0000010, DR=3, SA=1, SB=2) with imem_valid on the first FETCH cycle -> rf_we high for exactly 1 cycle at cycle 3, fs=00010, rf_wa=3; next imem_addr=1.
REQ-033 SHALL cover: imem_valid delayed 4 cycles -> imem_req and imem_addr held constant for 5 cycles, IR captured only on the valid cycle.
REQ-034 SHALL cover: SUB setting Z (alu_z=1), then BZ imm15=0x7FFE at PC=5 -> next PC=5+1-2=4; BNZ in the same case -> PC=6.
REQ-035 SHALL cover: opcode 0001100 (FS 01100) -> illegal=1, halted=1, rf_we never asserted, imem_req stays 0 thereafter.
REQ-036 SHALL cover: HALT at PC=0xFFFFFFFF -> halted=1 and PC unchanged; JMP imm15=0 at PC=0xFFFFFFFF -> PC=0.
REQ-037 SHALL cover: rst_n pulsed low during EXECUTE of an ALU instruction -> rf_we=0 that cycle, PC=0, and with CTRL_RETIRE_CNT_EN defined, retired=0.
